// File: rtl/axis_fifo_stream.sv
// First-word-fall-through AXI4-Stream FIFO storing {tlast,tdata} per beat.
// Define AXIS_FIFO_FLAGS_EN to add registered almost_full / almost_empty outputs.
module axis_fifo_stream #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   fill_count
`ifdef AXIS_FIFO_FLAGS_EN
  ,
  output logic                     almost_full,
  output logic                     almost_empty
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W:0]    mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fill_next;
  logic               wr_en;
  logic               rd_en;

  // Ready depends only on the registered count, so a read never frees a slot
  // in the same cycle and there is no path from m_axis_tready to s_axis_tready.
  assign s_axis_tready = (fill_count != CNT_W'(DEPTH));
  assign m_axis_tvalid = (fill_count != '0);
  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign rd_en         = m_axis_tvalid && m_axis_tready;

  assign m_axis_tdata  = mem[rd_ptr][DATA_W-1:0];
  assign m_axis_tlast  = mem[rd_ptr][DATA_W];

  always_comb begin
    fill_next = fill_count;
    case ({wr_en, rd_en})
      2'b10:   fill_next = fill_count + CNT_W'(1);
      2'b01:   fill_next = fill_count - CNT_W'(1);
      default: fill_next = fill_count;
    endcase
  end

  // NOTE: storage has no reset; contents are only visible once tvalid is high,
  // and leaving it unreset lets the array map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      fill_count <= fill_next;
    end
  end

`ifdef AXIS_FIFO_FLAGS_EN
  // Flags are computed from the next count so they change with fill_count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (fill_next >= CNT_W'(AF_LEVEL));
      almost_empty <= (fill_next <= CNT_W'(AE_LEVEL));
    end
  end
`endif

endmodule

// File: doc/axis_fifo_stream.md
AXIS_FIFO_STREAM -- requirements
Module: axis_fifo_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning tdata width in bits (1..1024).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning entry count (power of two, 2..1024).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full threshold (1..DEPTH-1).
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning almost_empty threshold (1..DEPTH-1).
REQ-005 The block SHALL have the following ports (one clock; reset synchronous, active-high):
- clk_i  input  1  clock; all logic on its rising edge.
- rst_i  input  1  synchronous reset, active-high.
- s_axis_tdata  input  DATA_W  write data.
- s_axis_tlast  input  1  end-of-packet marker, stored with data.
- s_axis_tvalid  input  1  upstream has a beat.
- s_axis_tready  output  1  FIFO can accept a beat.
- m_axis_tdata  output  DATA_W  head-of-FIFO data.
- m_axis_tlast  output  1  head-of-FIFO tlast.
- m_axis_tvalid  output  1  head entry valid.
- m_axis_tready  input  1  downstream accepts a beat.
- fill_count  output  $clog2(DEPTH)+1  stored entries, 0..DEPTH.
- almost_full  output  1  present only with AXIS_FIFO_FLAGS_EN.
- almost_empty  output  1  present only with AXIS_FIFO_FLAGS_EN.

Function
REQ-006 A write SHALL occur on an edge where s_axis_tvalid && s_axis_tready; {tlast,tdata} goes to mem[wr_ptr] and wr_ptr advances.
REQ-007 A read SHALL occur on an edge where m_axis_tvalid && m_axis_tready; rd_ptr advances.
REQ-008 s_axis_tready SHALL equal (fill_count != DEPTH), with no combinational path from m_axis_tready.
REQ-009 m_axis_tvalid SHALL equal (fill_count != 0); m_axis_tdata/tlast SHALL show mem[rd_ptr] (first-word fall-through).
REQ-010 A beat written into an empty FIFO SHALL appear on m_axis the cycle after the write edge (1-cycle latency).
REQ-011 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 by natural overflow.
REQ-012 fill_count SHALL be +1 on write only, -1 on read only, and unchanged on simultaneous write and read.
REQ-013 When full, a simultaneous read SHALL NOT enable a write in the same cycle; tready rises the following cycle.
REQ-014 When empty, a write SHALL be accepted and no read SHALL occur in that cycle.
REQ-015 Once m_axis_tvalid is high, tdata/tlast SHALL stay stable until the read edge (AXI4-Stream rule).
REQ-016 The block SHALL NOT alter, drop or reorder beats; tlast SHALL travel with its beat.

Reset
REQ-017 With rst_i high at an edge, wr_ptr, rd_ptr and fill_count SHALL clear to 0, giving s_axis_tready=1, m_axis_tvalid=0, fill_count=0, almost_full=0 and almost_empty=1.
REQ-018 Memory contents SHALL NOT be cleared; m_axis_tdata is don't-care while m_axis_tvalid=0.
REQ-019 A reset asserted mid-transfer SHALL discard all stored beats, and any handshake in that cycle SHALL be ignored.

Configuration
REQ-020 Macro AXIS_FIFO_FLAGS_EN defined: almost_full SHALL be registered high when the next fill_count >= AF_LEVEL.
REQ-021 With the same macro, almost_empty SHALL be registered high when the next fill_count <= AE_LEVEL; both flags update in the same cycle as fill_count.
REQ-022 Macro undefined: almost_full and almost_empty ports and their logic SHALL be absent; all other behaviour is identical.

Verification (DATA_W=32, DEPTH=8, flags enabled, AF_LEVEL=6, AE_LEVEL=2)
REQ-023 Reset, then write 0xA5A5_0001 with tlast=1 -> next cycle m_axis_tvalid=1, tdata=0xA5A5_0001, tlast=1, fill_count=1.
REQ-024 With m_axis_tready=0, write 9 beats 0x10..0x18 -> 8 accepted, s_axis_tready=0, fill_count=8, almost_full high from count 6, 0x18 not stored.
REQ-025 From full, drain with m_axis_tready=1 -> out 0x10..0x17 in order, almost_empty high at count<=2, tvalid=0 at count 0.
REQ-026 Run 20 cycles of simultaneous write and read at count 3 -> fill_count stays 3, data in order, pointers wrap with no loss.
REQ-027 Raise rst_i with 5 beats stored and tvalid/tready both high -> next cycle fill_count=0, tvalid=0, tready=1, and the stored beats are not output afterwards.
REQ-028 Hold m_axis_tready low for 4 cycles at count 2 -> m_axis_tdata/tlast stay constant, then beats are read in order.
